mips_debug_controller: RTL and testbench
========================================

// Module: mips_debug_controller
// PURPOSE
//  Host-side sequencer for the 5-stage MIPS core. Decodes byte commands from the UART RX and
//  loads program words into the IF instruction memory. Runs or single-steps the core through
//  its halt input, then streams a pipeline snapshot back through the UART TX.
//  Sits between the UART pair and the MIPS top.
// PARAMETERS
//  NB_DATA     32        instruction word width
//  NB_SNAP     304       snapshot width, a multiple of 8 bits ({ID_EX,EX_MEM,MEM_WB,WB_ID,CTRL,PC_LSB})
//  RUN_TIMEOUT 1048576   maximum RUN cycles before a forced stop
// PORTS
//  clk                  in   1        system clock
//  i_reset              in   1        asynchronous reset, active-low
//  i_rx_data            in   8        received byte
//  i_rx_valid           in   1        1-cycle strobe: i_rx_data is valid
//  o_tx_data            out  8        byte to transmit
//  o_tx_start           out  1        1-cycle strobe: start transmitting o_tx_data
//  i_tx_done            in   1        1-cycle strobe: TX is finished and idle
//  i_end                in   1        core has reached end of program (o_end of the core)
//  i_snapshot           in   NB_SNAP  concatenated segment/control registers; MSB byte is sent first
//  o_mips_reset         out  1        active-high reset to the core
//  o_we_IF              out  1        instruction memory write enable
//  o_instruction_data   out  NB_DATA  word to write
//  o_instruction_addr   out  NB_DATA  byte address of the write
//  o_halt               out  1        1 = core frozen
//  o_busy               out  1        0 only in IDLE
// BEHAVIOUR
//  Reset values: o_halt=1, o_mips_reset=1, all other outputs 0, state=IDLE.
//  Any reset assertion mid-operation aborts the operation and returns to these values.
//  o_mips_reset is held high through the first clk edge after reset release, then low.
//  Commands in IDLE (ASCII):
//    'L'  load
//    'R'  run
//    'S'  step
//    'D'  dump
//    'X'  o_mips_reset=1 for exactly 1 cycle; the load address is cleared to 0
//    any other byte: transmit 0x3F and return to IDLE
//  States: IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, DMP_LD, DMP_TX, DMP_WT.
//  LOAD:
//    - LD_CNT takes the next byte as word count N. N=0 returns to IDLE with no write.
//    - LD_BYTE shifts in 4 bytes per word, MSB first.
//    - LD_WR drives o_we_IF=1 for exactly 1 cycle with the assembled word at the current
//      address. The address then increments by 4 and wraps modulo 2^NB_DATA.
//    - After N words, transmit 0x4B ('K') and return to IDLE.
//    - RX bytes are never dropped: each i_rx_valid pulse is consumed in the same cycle.
//  RUN:
//    - o_halt=0 from the cycle after 'R' is accepted.
//    - o_halt=1 on the cycle that i_end=1 is sampled, or when the cycle counter reaches
//      RUN_TIMEOUT; then go to DMP_LD.
//    - A timeout first transmits 0x54 ('T') and then dumps.
//    - If i_end is already 1 when 'R' arrives, o_halt stays 1 and the block goes straight
//      to DMP_LD.
//  STEP: o_halt=0 for exactly 1 clk cycle, then DMP_LD. Step is allowed even when i_end=1.
//  DUMP ('D', or automatically after RUN/STEP):
//    - DMP_LD latches i_snapshot into a shift register. The core is halted, so the value
//      is stable.
//    - DMP_TX pulses o_tx_start with the top byte.
//    - DMP_WT waits for i_tx_done, then shifts left 8 bits.
//    - After NB_SNAP/8 bytes (38 with defaults), return to IDLE.
//    - i_tx_done outside DMP_WT is ignored.
//  Single-byte replies ('K', 0x3F, 'T') use the same TX/done handshake before continuing.
//  RX bytes arriving in RUN/STEP/DUMP/reply states are discarded; there is no queueing.
//  o_instruction_addr holds its value between loads, so successive 'L' commands append.
// TESTING
//  1. Reset, then 'L',0x02,{00,00,00,01},{DE,AD,BE,EF} -> two o_we_IF pulses:
//     addr 0 data 0x00000001, then addr 4 data 0xDEADBEEF; TX sends 0x4B.
//  2. 'S' with i_snapshot=0x0102..26 (38 bytes) -> o_halt low for exactly 1 cycle;
//     TX sends 0x01..0x26 in order, each byte only after i_tx_done.
//  3. 'R' with i_end raised after 50 cycles -> o_halt low for exactly 50 cycles; 38-byte dump follows.
//  4. 'R' with RUN_TIMEOUT=16 and i_end=0 -> halt after 16 cycles; TX sends 0x54, then the 38-byte dump.
//  5. Byte 0x41 in IDLE -> TX 0x3F; 'X' -> o_mips_reset 1-cycle pulse; next 'L',0x01 writes addr 0.
//  6. Assert i_reset during the 3rd byte of a load -> outputs return to reset values;
//     a fresh load starts at addr 0.

Source files
------------

// File: rtl/mips_debug_controller.sv
// Host-side debug sequencer for the 5-stage MIPS core: decodes UART commands, loads
// instruction memory, runs/steps the core through o_halt and streams back a pipeline snapshot.
`default_nettype none

module mips_debug_controller #(
    parameter int NB_DATA     = 32,
    parameter int NB_SNAP     = 304,
    parameter int RUN_TIMEOUT = 1048576
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    input  logic               i_end,
    input  logic [NB_SNAP-1:0] i_snapshot,
    output logic               o_mips_reset,
    output logic               o_we_IF,
    output logic [NB_DATA-1:0] o_instruction_data,
    output logic [NB_DATA-1:0] o_instruction_addr,
    output logic               o_halt,
    output logic               o_busy
);

    localparam int WB  = NB_DATA / 8;
    localparam int IW  = (WB > 1) ? $clog2(WB) : 1;
    localparam int RW  = $clog2(RUN_TIMEOUT + 1);
    localparam int NBY = NB_SNAP / 8;
    localparam int DW  = $clog2(NBY + 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(RUN_TIMEOUT);
    localparam logic [IW-1:0] IDX_LAST  = IW'(WB - 1);
    localparam logic [DW-1:0] DUMP_LAST = DW'(NBY - 1);

    typedef enum logic [3:0] {
        IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP,
        DMP_LD, DMP_TX, DMP_WT, RPL_TX, RPL_WT
    } state_e;

    state_e               state_q, state_d;
    logic [NB_DATA-1:0]   addr_q, addr_d;
    logic [NB_DATA-1:0]   word_q, word_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [RW-1:0]        run_q, run_d;
    logic [NB_SNAP-1:0]   snap_q, snap_d;
    logic [DW-1:0]        dcnt_q, dcnt_d;
    logic [7:0]           rpl_q, rpl_d;
    logic                 rpl_dump_q, rpl_dump_d;
    logic                 mrst_q, mrst_d;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            run_q      <= '0;
            snap_q     <= '0;
            dcnt_q     <= '0;
            rpl_q      <= '0;
            rpl_dump_q <= 1'b0;
            mrst_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            run_q      <= run_d;
            snap_q     <= snap_d;
            dcnt_q     <= dcnt_d;
            rpl_q      <= rpl_d;
            rpl_dump_q <= rpl_dump_d;
            mrst_q     <= mrst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        run_d      = run_q;
        snap_d     = snap_q;
        dcnt_d     = dcnt_q;
        rpl_d      = rpl_q;
        rpl_dump_d = rpl_dump_q;
        mrst_d     = 1'b0;
        o_we_IF    = 1'b0;
        o_tx_start = 1'b0;
        o_tx_data  = 8'h00;
        o_halt     = 1'b1;

        case (state_q)
            IDLE: begin
                run_d = '0;
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h4C: state_d = LD_CNT;
                        8'h52: state_d = i_end ? DMP_LD : RUN;
                        8'h53: state_d = STEP;
                        8'h44: state_d = DMP_LD;
                        8'h58: begin
                            mrst_d = 1'b1;
                            addr_d = '0;
                        end
                        default: begin
                            rpl_d      = 8'h3F;
                            rpl_dump_d = 1'b0;
                            state_d    = RPL_TX;
                        end
                    endcase
                end
            end
            LD_CNT: begin
                if (i_rx_valid) begin
                    cnt_d   = i_rx_data;
                    idx_d   = '0;
                    state_d = (i_rx_data == 8'h00) ? IDLE : LD_BYTE;
                end
            end
            LD_BYTE: begin
                if (i_rx_valid) begin
                    word_d = {word_q[NB_DATA-9:0], i_rx_data};
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = LD_WR;
                end
            end
            LD_WR: begin
                o_we_IF = 1'b1;
                addr_d  = addr_q + NB_DATA'(4);
                cnt_d   = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    rpl_d      = 8'h4B;
                    rpl_dump_d = 1'b0;
                    state_d    = RPL_TX;
                end else begin
                    // A back-to-back first byte of the next word lands here and must be kept.
                    state_d = LD_BYTE;
                    idx_d   = '0;
                    if (i_rx_valid) begin
                        word_d = {word_q[NB_DATA-9:0], i_rx_data};
                        idx_d  = IW'(1);
                    end
                end
            end
            RUN: begin
                if (i_end) begin
                    state_d = DMP_LD;
                end else if (run_q == RUN_MAX) begin
                    rpl_d      = 8'h54;
                    rpl_dump_d = 1'b1;
                    state_d    = RPL_TX;
                end else begin
                    o_halt = 1'b0;
                    run_d  = run_q + 1'b1;
                end
            end
            STEP: begin
                o_halt  = 1'b0;
                state_d = DMP_LD;
            end
            DMP_LD: begin
                snap_d  = i_snapshot;
                dcnt_d  = '0;
                state_d = DMP_TX;
            end
            DMP_TX: begin
                o_tx_start = 1'b1;
                o_tx_data  = snap_q[NB_SNAP-1 -: 8];
                state_d    = DMP_WT;
            end
            DMP_WT: begin
                if (i_tx_done) begin
                    snap_d = snap_q << 8;
                    if (dcnt_q == DUMP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        dcnt_d  = dcnt_q + 1'b1;
                        state_d = DMP_TX;
                    end
                end
            end
            RPL_TX: begin
                o_tx_start = 1'b1;
                o_tx_data  = rpl_q;
                state_d    = RPL_WT;
            end
            RPL_WT: begin
                if (i_tx_done) state_d = rpl_dump_q ? DMP_LD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_mips_reset       = mrst_q;
    assign o_instruction_addr = addr_q;
    assign o_instruction_data = word_q;
    assign o_busy             = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mips_debug_controller.sv
// Directed bench for mips_debug_controller: load, step, run, timeout, reply and reset scenarios.
`default_nettype none

module tb_mips_debug_controller;

    localparam int NB_DATA = 32;
    localparam int NB_SNAP = 304;
    localparam int TMO     = 64;   // must exceed the 50-cycle run scenario
    localparam int NBY     = NB_SNAP / 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         rx_data = 8'h00;
    logic               rx_valid = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_done = 1'b0;
    logic               core_end = 1'b0;
    logic [NB_SNAP-1:0] snap = '0;
    logic               mips_rst, we, halt, busy;
    logic [NB_DATA-1:0] idata, iaddr;

    mips_debug_controller #(
        .NB_DATA(NB_DATA), .NB_SNAP(NB_SNAP), .RUN_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
        .i_end(core_end), .i_snapshot(snap), .o_mips_reset(mips_rst),
        .o_we_IF(we), .o_instruction_data(idata), .o_instruction_addr(iaddr),
        .o_halt(halt), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [7:0]  txq[$];
    logic [31:0] wea[$], wed[$];
    int halt_low = 0, mrst_cnt = 0, start_cnt = 0;

    always @(negedge clk) begin
        if (we) begin
            wea.push_back(iaddr);
            wed.push_back(idata);
        end
        if (!halt) halt_low++;
        if (mips_rst) mrst_cnt++;
        if (tx_start) start_cnt++;
    end

    // TX model: accepts one byte, reports done three cycles later; starts issued while busy are lost.
    always begin
        @(negedge clk);
        if (tx_start) begin
            txq.push_back(tx_data);
            repeat (3) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step_clk();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            step_clk();
            n++;
        end
        check({tag, " idle"}, 64'(n < 2000), 64'd1);
    endtask

    task automatic clear_mon;
        txq.delete();
        wea.delete();
        wed.delete();
        halt_low  = 0;
        mrst_cnt  = 0;
        start_cnt = 0;
    endtask

    task automatic check_dump(input string tag, input int off);
        for (int i = 0; i < NBY; i++)
            check($sformatf("%s byte%0d", tag, i), 64'(txq[off+i]), 64'(i + 1));
        check({tag, " tx count"}, 64'(txq.size()), 64'(off + NBY));
        check({tag, " no lost start"}, 64'(start_cnt), 64'(txq.size()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NBY; i++) snap[NB_SNAP-1-8*i -: 8] = 8'(i + 1);

        // Reset values
        repeat (3) step_clk();
        check("rst halt", 64'(halt), 64'd1);
        check("rst mips_reset", 64'(mips_rst), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst we", 64'(we), 64'd0);
        check("rst tx_start", 64'(tx_start), 64'd0);
        check("rst addr", 64'(iaddr), 64'd0);
        rst_n = 1'b1;
        #3;
        check("mips_reset before 1st edge", 64'(mips_rst), 64'd1);
        step_clk();
        check("mips_reset after 1st edge", 64'(mips_rst), 64'd0);
        clear_mon();

        // Two-word load, bytes back to back
        send(8'h4C); send(8'h02);
        send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        wait_idle("load2");
        check("load2 writes", 64'(wea.size()), 64'd2);
        check("load2 addr0", 64'(wea[0]), 64'h0);
        check("load2 data0", 64'(wed[0]), 64'h00000001);
        check("load2 addr1", 64'(wea[1]), 64'h4);
        check("load2 data1", 64'(wed[1]), 64'hDEADBEEF);
        check("load2 reply", 64'(txq[0]), 64'h4B);
        check("load2 tx count", 64'(txq.size()), 64'd1);
        check("load2 next addr", 64'(iaddr), 64'h8);

        // Zero word count: no write, no reply
        clear_mon();
        send(8'h4C); send(8'h00);
        step_clk();
        check("load0 busy", 64'(busy), 64'd0);
        check("load0 writes", 64'(wea.size()), 64'd0);
        check("load0 tx", 64'(start_cnt), 64'd0);

        // Single step
        clear_mon();
        send(8'h53);
        wait_idle("step");
        check("step halt low", 64'(halt_low), 64'd1);
        check_dump("step", 0);

        // Run, end after 50 cycles
        clear_mon();
        send(8'h52);
        repeat (50) step_clk();
        core_end = 1'b1;
        wait_idle("run50");
        check("run50 halt low", 64'(halt_low), 64'd50);
        check_dump("run50", 0);

        // Run with end already high: straight to dump
        clear_mon();
        send(8'h52);
        wait_idle("run_end");
        check("run_end halt low", 64'(halt_low), 64'd0);
        check("run_end tx count", 64'(txq.size()), 64'(NBY));
        core_end = 1'b0;

        // Run to timeout
        clear_mon();
        send(8'h52);
        wait_idle("tmo");
        check("tmo halt low", 64'(halt_low), 64'(TMO));
        check("tmo reply", 64'(txq[0]), 64'h54);
        check_dump("tmo", 1);

        // Unknown byte, append load, 'X', then load from 0
        clear_mon();
        send(8'h41);
        wait_idle("unk");
        check("unk reply", 64'(txq[0]), 64'h3F);
        check("unk tx count", 64'(txq.size()), 64'd1);
        clear_mon();
        send(8'h4C); send(8'h01);
        send(8'hCA); send(8'hFE); send(8'hF0); send(8'h0D);
        wait_idle("append");
        check("append addr", 64'(wea[0]), 64'h8);
        check("append data", 64'(wed[0]), 64'hCAFEF00D);
        clear_mon();
        send(8'h58);
        repeat (3) step_clk();
        check("X pulse cycles", 64'(mrst_cnt), 64'd1);
        send(8'h4C); send(8'h01);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_idle("afterX");
        check("afterX addr", 64'(wea[0]), 64'h0);
        check("afterX data", 64'(wed[0]), 64'h11223344);

        // Reset during the third load byte
        send(8'h4C); send(8'h02); send(8'hAA); send(8'hBB);
        rx_data  = 8'hCC;
        rx_valid = 1'b1;
        rst_n    = 1'b0;
        #2;
        check("midrst halt", 64'(halt), 64'd1);
        check("midrst mips_reset", 64'(mips_rst), 64'd1);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst we", 64'(we), 64'd0);
        check("midrst addr", 64'(iaddr), 64'd0);
        rx_valid = 1'b0;
        step_clk();
        rst_n = 1'b1;
        step_clk();
        clear_mon();
        send(8'h4C); send(8'h01);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        wait_idle("fresh");
        check("fresh writes", 64'(wea.size()), 64'd1);
        check("fresh addr", 64'(wea[0]), 64'h0);
        check("fresh data", 64'(wed[0]), 64'h55667788);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
